// File: rtl/i2c_txn_arbiter_pkg.sv
// I2C mode constants, command record and FSM state types shared by the arbiter and its round-robin picker.
// Mode classes decide which master ack pulse ends a transaction.
package i2c_txn_arbiter_pkg;

   localparam logic [7:0] I2C_Wait          = 8'h00;
   localparam logic [7:0] I2C_Write_Reg     = 8'h01;
   localparam logic [7:0] I2C_Write_Cmd     = 8'h02;
   localparam logic [7:0] I2C_Write_Direct  = 8'h03;
   localparam logic [7:0] I2C_Read_Reg      = 8'h04;
   localparam logic [7:0] I2C_Read_Burst    = 8'h05;
   localparam logic [7:0] I2C_Read_Directly = 8'h06;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      MODE_ILLEGAL = 2'd0,
      MODE_WRITE   = 2'd1,
      MODE_READ    = 2'd2
   } mode_class_t;

   typedef struct packed {
      logic [7:0] cfg;
      logic [6:0] dev_addr;
      logic [7:0] reg_addr;
      logic [7:0] wdata;
      logic [7:0] num;
   } cmd_t;

   function automatic mode_class_t mode_class(input logic [7:0] cfg);
      if (cfg >= I2C_Write_Reg && cfg <= I2C_Write_Direct)
         return MODE_WRITE;
      else if (cfg >= I2C_Read_Reg && cfg <= I2C_Read_Directly)
         return MODE_READ;
      else
         return MODE_ILLEGAL;
   endfunction

endpackage

// File: rtl/i2c_txn_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping; zero latency.
// No backpressure of its own; the caller decides when the pick is taken.
module rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int PW      = 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PW-1:0]      ptr,
   output logic               any_vld,
   output logic [NUM_REQ-1:0] win_oh,
   output logic [PW-1:0]      win_idx
);

   // Scan from the farthest offset down so the nearest requester overwrites last.
   always_comb begin
      any_vld = 1'b0;
      win_oh  = '0;
      win_idx = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (req[(int'(ptr) + k) % NUM_REQ]) begin
            any_vld = 1'b1;
            win_idx = PW'((int'(ptr) + k) % NUM_REQ);
            win_oh  = '0;
            win_oh[(int'(ptr) + k) % NUM_REQ] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// Shares one I2C master among NUM_REQ requesters: grant 1 cycle after req_valid, done on matching ack or timeout.
// Requesters hold req_valid until grant; new requests wait while busy (transaction plus GAP_CYC idle cycles).
module i2c_txn_arbiter
   import i2c_txn_arbiter_pkg::*;
#(
   parameter int NUM_REQ     = 2,
   parameter int GAP_CYC     = 16,
   parameter int TIMEOUT_CYC = 2000000
) (
   input  logic                   clk_in,
   input  logic                   rst_n,
   input  logic [NUM_REQ-1:0]     req_valid,
   input  logic [8*NUM_REQ-1:0]   req_config,
   input  logic [7*NUM_REQ-1:0]   req_dev_addr,
   input  logic [8*NUM_REQ-1:0]   req_reg_addr,
   input  logic [8*NUM_REQ-1:0]   req_wdata,
   input  logic [8*NUM_REQ-1:0]   req_num,
   output logic [NUM_REQ-1:0]     grant,
   output logic [NUM_REQ-1:0]     done,
   output logic                   err,
   output logic                   busy,
   input  logic                   i2c_wr_done_in,
   input  logic                   i2c_rd_done_in,
   output logic [7:0]             i2c_config,
   output logic [6:0]             i2c_device_address,
   output logic [7:0]             i2c_reg_address,
   output logic [7:0]             i2c_write_reg_data,
   output logic [7:0]             i2c_data_num
);

   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam int GW = $clog2(GAP_CYC + 1);

   state_t              state_q, state_d;
   cmd_t                cmd_q, cmd_d;
   mode_class_t         cls_q, cls_d;
   logic [PW-1:0]       ptr_q, ptr_d;
   logic [PW-1:0]       owner_q, owner_d;
   logic [TW-1:0]       timer_q, timer_d;
   logic [GW-1:0]       gap_q, gap_d;
   logic [NUM_REQ-1:0]  grant_d, done_d;
   logic                err_d, busy_d;
   logic                finish;

   logic                any_vld;
   logic [NUM_REQ-1:0]  win_oh;
   logic [PW-1:0]       win_idx;
   cmd_t                req_cmd [NUM_REQ];

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign req_cmd[i] = '{cfg:      req_config[8*i +: 8],
                            dev_addr: req_dev_addr[7*i +: 7],
                            reg_addr: req_reg_addr[8*i +: 8],
                            wdata:    req_wdata[8*i +: 8],
                            num:      req_num[8*i +: 8]};
   end

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .PW      (PW)
   ) u_rr (
      .req     (req_valid),
      .ptr     (ptr_q),
      .any_vld (any_vld),
      .win_oh  (win_oh),
      .win_idx (win_idx)
   );

   always_comb begin
      state_d = state_q;
      cmd_d   = cmd_q;
      cls_d   = cls_q;
      ptr_d   = ptr_q;
      owner_d = owner_q;
      timer_d = timer_q;
      gap_d   = gap_q;
      busy_d  = busy;
      grant_d = '0;
      done_d  = '0;
      err_d   = 1'b0;
      finish  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (any_vld) begin
               grant_d = win_oh;
               busy_d  = 1'b1;
               owner_d = win_idx;
               ptr_d   = (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + 1'b1;
               cmd_d   = req_cmd[win_idx];
               cls_d   = mode_class(req_cmd[win_idx].cfg);
               // An illegal mode must never reach the master.
               if (cls_d == MODE_ILLEGAL)
                  cmd_d.cfg = I2C_Wait;
               timer_d = '0;
               state_d = ST_BUSY;
            end
         end

         ST_BUSY: begin
            timer_d = timer_q + 1'b1;
            if (cls_q == MODE_ILLEGAL) begin
               finish = 1'b1;
               err_d  = 1'b1;
            end else if ((cls_q == MODE_WRITE && i2c_wr_done_in) ||
                         (cls_q == MODE_READ  && i2c_rd_done_in)) begin
               // Checked before the timeout so a same-cycle ack still counts as success.
               finish = 1'b1;
            end else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
               finish = 1'b1;
               err_d  = 1'b1;
            end
            if (finish) begin
               done_d[owner_q] = 1'b1;
               cmd_d.cfg       = I2C_Wait;
               gap_d           = '0;
               state_d         = ST_GAP;
            end
         end

         ST_GAP: begin
            if (gap_q == GW'(GAP_CYC - 1)) begin
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end

         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cmd_q   <= '0;
         cls_q   <= MODE_ILLEGAL;
         ptr_q   <= '0;
         owner_q <= '0;
         timer_q <= '0;
         gap_q   <= '0;
         grant   <= '0;
         done    <= '0;
         err     <= 1'b0;
         busy    <= 1'b0;
      end else begin
         state_q <= state_d;
         cmd_q   <= cmd_d;
         cls_q   <= cls_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         timer_q <= timer_d;
         gap_q   <= gap_d;
         grant   <= grant_d;
         done    <= done_d;
         err     <= err_d;
         busy    <= busy_d;
      end
   end

   assign i2c_config         = cmd_q.cfg;
   assign i2c_device_address = cmd_q.dev_addr;
   assign i2c_reg_address    = cmd_q.reg_addr;
   assign i2c_write_reg_data = cmd_q.wdata;
   assign i2c_data_num       = cmd_q.num;

endmodule
